// File: rtl/elastic_delay_pipe.sv
// rtl/elastic_delay_pipe.sv - N-stage valid/ready delay line with bubble collapse, flush and occupancy count
module elastic_delay_pipe #(
    parameter int               N           = 3,
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(N+1)-1:0]   count
);

    localparam int CW = $clog2(N + 1);

    logic [N-1:0]     v;
    logic [WIDTH-1:0] d [N];
    logic [N-1:0]     adv;
    logic             stage0_free;
    logic             in_xfer;
    logic             out_xfer;

    // Backward ready chain: a stage advances if out_ready is high or any later stage holds a bubble.
    always_comb begin
        adv         = '0;
        stage0_free = out_ready;
        for (int i = N - 1; i >= 0; i--) begin
            adv[i]      = stage0_free;
            stage0_free = stage0_free || !v[i];
        end
    end

    assign in_ready  = stage0_free && !flush && !reset;
    assign out_valid = v[N-1] && !flush && !reset;
    assign out_data  = d[N-1];
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            v     <= '0;
            count <= '0;
            for (int i = 0; i < N; i++) begin
                d[i] <= RESET_VALUE;
            end
        end else if (flush) begin
            // Data registers are deliberately left alone; only occupancy is discarded.
            v     <= '0;
            count <= '0;
        end else begin
            for (int i = 1; i < N; i++) begin
                if (adv[i-1]) begin
                    v[i] <= v[i-1];
                    d[i] <= d[i-1];
                end
            end
            if (in_xfer) begin
                v[0] <= 1'b1;
                d[0] <= in_data;
            end else if (adv[0]) begin
                v[0] <= 1'b0;
            end
            count <= count + CW'(in_xfer) - CW'(out_xfer);
        end
    end

endmodule

// File: tb/tb_elastic_delay_pipe.sv
// tb/tb_elastic_delay_pipe.sv - randomized and directed bench for elastic_delay_pipe against a queue model
module tb_elastic_delay_pipe;

    localparam int N = 3;
    localparam int WIDTH = 8;
    localparam logic [7:0] RV = 8'h5A;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;

    elastic_delay_pipe #(.N(N), .WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Model: in-flight entries oldest first, each with the stage it currently occupies.
    typedef struct {
        logic [7:0] data;
        int         pos;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic iv, input logic [7:0] id, input logic ordy,
                        input logic fl, input logic rst, output logic acc);
        int         np[$];
        logic       e_ir;
        logic       e_ov;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        #1;
        // Each entry moves one stage forward unless the slot ahead is still occupied; N means it left.
        np = {};
        for (int k = 0; k < q.size(); k++) begin
            if (k == 0)
                np.push_back(q[0].pos == N - 1 ? (ordy ? N : N - 1) : q[0].pos + 1);
            else
                np.push_back(q[k].pos + 1 < np[k-1] ? q[k].pos + 1 : q[k].pos);
        end
        if (rst || fl) begin
            e_ir = 1'b0;
            e_ov = 1'b0;
        end else begin
            e_ov = (q.size() > 0) && (q[0].pos == N - 1);
            if (q.size() == 0) e_ir = 1'b1;
            else               e_ir = np[np.size()-1] > 0;
        end
        check("in_ready", 32'(in_ready), 32'(e_ir));
        check("out_valid", 32'(out_valid), 32'(e_ov));
        check("count", 32'(count), q.size());
        if (e_ov) check("out_data", 32'(out_data), 32'(q[0].data));
        acc = iv && e_ir;
        if (rst || fl) begin
            q.delete();
        end else begin
            for (int k = 0; k < q.size(); k++) q[k].pos = np[k];
            if (q.size() > 0 && q[0].pos == N) void'(q.pop_front());
            if (acc) q.push_back('{data: id, pos: 0});
        end
        cyc++;
    endtask

    initial begin
        logic       acc;
        logic [7:0] vals [4];
        int         idx;

        // Reset, then the post-reset idle state
        step(0, 8'h00, 0, 0, 1, acc);
        step(0, 8'h00, 0, 0, 1, acc);
        step(0, 8'h00, 0, 0, 0, acc);
        check("post_reset_out_data", 32'(out_data), 32'(RV));
        check("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Streaming with out_ready high
        step(1, 8'h11, 1, 0, 0, acc);
        step(1, 8'h22, 1, 0, 0, acc);
        step(1, 8'h33, 1, 0, 0, acc);
        step(1, 8'h44, 1, 0, 0, acc);
        check("stream_first_out", 32'(out_data), 32'h11);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 0, acc);

        // Backpressure fill, then release
        vals = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, vals[idx], 0, 0, 0, acc);
            if (acc) idx++;
        end
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_count", 32'(count), 32'd3);
        check("bp_hold_data", 32'(out_data), 32'hA1);
        for (int i = 0; i < 10; i++) begin
            step(idx < 4, vals[idx < 4 ? idx : 3], 1, 0, 0, acc);
            if (acc) idx++;
        end

        // Bubble collapse
        step(1, 8'h01, 0, 0, 0, acc);
        step(0, 8'h00, 0, 0, 0, acc);
        step(0, 8'h00, 0, 0, 0, acc);
        step(1, 8'h02, 0, 0, 0, acc);
        for (int i = 0; i < 6; i++) step(0, 8'h00, 0, 0, 0, acc);
        check("bubble_count", 32'(count), 32'd2);
        check("bubble_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0, acc);

        // Full with simultaneous in/out transfer
        step(1, 8'hB1, 0, 0, 0, acc);
        step(1, 8'hB2, 0, 0, 0, acc);
        step(1, 8'hB3, 0, 0, 0, acc);
        step(1, 8'hB4, 1, 0, 0, acc);
        check("full_in_ready", 32'(in_ready), 32'd1);
        check("full_out_data", 32'(out_data), 32'hB1);
        step(0, 8'h00, 0, 0, 0, acc);
        check("full_count_kept", 32'(count), 32'd3);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 0, acc);

        // Flush with two entries in flight and a flush-cycle input offer
        step(1, 8'hC1, 0, 0, 0, acc);
        step(1, 8'hC2, 0, 0, 0, acc);
        step(1, 8'hEE, 1, 1, 0, acc);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        step(0, 8'h00, 1, 0, 0, acc);
        check("flush_count", 32'(count), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0, acc);

        // Reset mid-stream
        step(1, 8'hD1, 0, 0, 0, acc);
        step(1, 8'hD2, 0, 0, 0, acc);
        step(0, 8'h00, 0, 0, 1, acc);
        step(0, 8'h00, 1, 0, 0, acc);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'(RV));
        check("rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0, acc);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 80) == 0), acc);
        end
        for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0, 0, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
